// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock supervisor.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    REPORT  = 2'd2,
    LATCHED = 2'd3
  } state_e;

  localparam int DEFAULT_THRESH = 1024;

  function automatic int calc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hls_deadlock_scheduler_rr_find_first.sv
// Rotate-priority finder: first set bit of vec at or above start, wrapping to bit 0.
module rr_find_first #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0] rot;

  // Rotate so the search always scans upward from bit 0.
  assign rot = N'({vec, vec} >> start);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/hls_deadlock_scheduler.sv
// Deadlock supervisor: persistence window, round-robin reporter, sticky flag.
// Optional macro HLS_DEADLOCK_TIMESTAMP_EN adds a cycle counter and rpt_time.
module hls_deadlock_scheduler
  import hls_deadlock_pkg::*;
#(
  parameter int N_MON  = 8,
  parameter int CNT_W  = 16,
  parameter int THRESH = DEFAULT_THRESH,
  localparam int IDX_W = calc_idx_w(N_MON)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_MON-1:0] block_sigs,
  input  logic             clear,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_idx,
  output logic [N_MON-1:0] rpt_mask,
`ifdef HLS_DEADLOCK_TIMESTAMP_EN
  output logic [CNT_W-1:0] rpt_time,
`endif
  output logic             deadlock,
  output logic             busy
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_MON-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]   ff_idx;
  logic               ff_found;
  logic               any_blk;
  logic [IDX_W-1:0]   next_ptr;

  assign any_blk  = |block_sigs;
  assign next_ptr = (idx_q == IDX_W'(N_MON - 1)) ? '0 : idx_q + 1'b1;

  rr_find_first #(
    .N     (N_MON),
    .IDX_W (IDX_W)
  ) u_find (
    .vec   (block_sigs),
    .start (rr_ptr_q),
    .idx   (ff_idx),
    .found (ff_found)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    unique case (state_q)
      IDLE: begin
        if (enable && any_blk) begin
          state_d = WATCH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WATCH: begin
        // Any gap in blocking restarts the persistence window.
        if (!enable || !any_blk) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == THR && ff_found) begin
          state_d = REPORT;
          idx_d   = ff_idx;
          mask_d  = block_sigs;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          state_d  = LATCHED;
          rr_ptr_d = next_ptr;
        end
      end
      LATCHED: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
    end
  end

`ifdef HLS_DEADLOCK_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q;
  logic [CNT_W-1:0] time_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q   <= '0;
      time_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (state_q == WATCH && state_d == REPORT) time_q <= ts_q;
    end
  end

  assign rpt_time = time_q;
`endif

  assign rpt_valid = (state_q == REPORT);
  assign deadlock  = (state_q == LATCHED);
  assign busy      = (state_q != IDLE);
  assign rpt_idx   = idx_q;
  assign rpt_mask  = mask_q;

endmodule
